// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM states, load-size codes and byte-enable constants
// Contents: state_t (IDLE, REQ, WAIT, DONE), EXTR_* load-size codes, BE_* lane masks,
// store_be() helper mapping store size and address lane to byte enables.
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [1:0] EXTR_WORD = 2'b00;
  localparam logic [1:0] EXTR_BYTE = 2'b01;
  localparam logic [1:0] EXTR_HALF = 2'b10;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic [3:0] store_be(input logic sb, input logic sh, input logic [1:0] lane);
    return sb ? BE_BYTE << lane : sh ? (lane[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/grant bus with rvalid read return
// Signals: req, we, be, addr, wdata (master->memory); gnt, rvalid, rdata (memory->master).
// Modports: master (access unit), slave (memory).
interface mem_access_if #(parameter int DATA_BITS = 32);
  logic req, we, gnt, rvalid;
  logic [3:0] be;
  logic [DATA_BITS-1:0] addr, wdata, rdata;
  modport master(output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_load_extract.sv
// mem_load_extract: selects the load lane from a read word and sign/zero extends it
// Ports: rdata (read word), lane (addr[1:0]), extr_word (size code), extr_signed, result.
// Half loads use lane[1] only and word loads ignore the lane, so misaligned lanes are forced aligned.
module mem_load_extract import mem_access_pkg::*; #(parameter int DATA_BITS = 32) (
  input  logic [DATA_BITS-1:0] rdata,
  input  logic [1:0]           lane,
  input  logic [1:0]           extr_word,
  input  logic                 extr_signed,
  output logic [DATA_BITS-1:0] result
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = rdata[{lane, 3'b000} +: 8];
  assign h = rdata[{lane[1], 4'b0000} +: 16];
  assign result = extr_word == EXTR_BYTE ? {{(DATA_BITS - 8){extr_signed & b[7]}}, b}
                : extr_word == EXTR_HALF ? {{(DATA_BITS - 16){extr_signed & h[15]}}, h}
                : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory controller with pipeline stall and timeout abort
// Ports: clk, rst (async, active-high); EX/MEM inputs in_valid, addr, wdata, MemWrite, MemToReg,
// Sb, Sh, ExtrWord, ExtrSigned; dm (mem_access_if.master) memory bus; outputs mem_stall,
// load_data (registered), load_valid and bus_err (one-cycle pulses).
// Option: MEM_MISALIGN_TRAP_EN adds output misalign and traps misaligned half/word accesses.
module mem_access_unit import mem_access_pkg::*; #(
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 MemWrite,
  input  logic                 MemToReg,
  input  logic                 Sb,
  input  logic                 Sh,
  input  logic [1:0]           ExtrWord,
  input  logic                 ExtrSigned,
  mem_access_if.master         dm,
  output logic                 mem_stall,
  output logic                 load_valid,
  output logic                 bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 misalign,
`endif
  output logic [DATA_BITS-1:0] load_data
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic access, mis, timeout, ld_q, err_q, we_q, signed_q;
  logic [1:0] lane_q, extr_q;
  logic [3:0] be_q;
  logic [DATA_BITS-1:0] addr_q, wdata_q, ext;
  assign access = in_valid & (MemWrite | MemToReg);
`ifdef MEM_MISALIGN_TRAP_EN
  logic half_sz, word_sz;
  assign half_sz = MemWrite ? Sh & !Sb : ExtrWord == EXTR_HALF;
  assign word_sz = MemWrite ? !(Sb | Sh) : ExtrWord[0] == ExtrWord[1];
  assign mis = (half_sz & addr[0]) | (word_sz & |addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  // only meaningful in REQ/WAIT: last counted cycle passed without the awaited handshake
  assign timeout = cnt == CW'(TIMEOUT_CYC - 1) && (state == REQ ? !dm.gnt : !dm.rvalid);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = access ? (mis ? DONE : REQ) : IDLE;
      REQ: next = dm.gnt ? (we_q ? DONE : WAIT) : timeout ? DONE : REQ;
      WAIT: next = dm.rvalid || timeout ? DONE : WAIT;
      DONE: next = IDLE;
    endcase
  end
  always_comb begin
    dm.req = state == REQ;
    dm.we = state == REQ && we_q;
    dm.be = state == REQ ? be_q : '0;
    mem_stall = !rst && (state == REQ || state == WAIT || (state == IDLE && access));
    load_valid = state == DONE && ld_q;
    bus_err = state == DONE && err_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = state == IDLE && access && mis;
`endif
  end
  assign dm.addr = addr_q;
  assign dm.wdata = wdata_q;
  mem_load_extract #(.DATA_BITS(DATA_BITS)) u_extract (
    .rdata(dm.rdata),
    .lane(lane_q),
    .extr_word(extr_q),
    .extr_signed(signed_q),
    .result(ext)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ld_q <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      signed_q <= 1'b0;
      lane_q <= '0;
      extr_q <= '0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      load_data <= '0;
    end else begin
      cnt <= (state == REQ || state == WAIT) && next == state ? cnt + 1'b1 : '0;
      if (state == IDLE && access) begin
        we_q <= MemWrite;
        ld_q <= !MemWrite && !mis;
        err_q <= 1'b0;
        signed_q <= ExtrSigned;
        lane_q <= addr[1:0];
        extr_q <= ExtrWord;
        be_q <= store_be(Sb, Sh, addr[1:0]);
        addr_q <= {addr[DATA_BITS-1:2], 2'b00};
        wdata_q <= Sb ? {4{wdata[7:0]}} : Sh ? {2{wdata[15:0]}} : wdata;
      end
      if ((state == REQ || state == WAIT) && timeout) begin
        ld_q <= 1'b0;
        err_q <= 1'b1;
      end
      if (state == WAIT && dm.rvalid) load_data <= ext;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  localparam int T = 16;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr, wdata;} req_t;
  typedef struct {int kind; logic [31:0] data;} resp_t;
  logic clk = 0, rst = 1, in_valid = 0, MemWrite = 0, MemToReg = 0, Sb = 0, Sh = 0, ExtrSigned = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [1:0] ExtrWord = 0;
  logic mem_stall, load_valid, bus_err;
  logic [31:0] load_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
`endif
  int checks = 0, failures = 0;
  int gnt_dly = 0, rv_dly = 0, waited = 0, rv_cnt = -1;
  logic [31:0] rd_val = 0, last_ld = 0;
  req_t req_q[$];
  resp_t resp_q[$];
  mem_access_if #(.DATA_BITS(32)) dm ();
  mem_access_unit #(.DATA_BITS(32), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .addr(addr), .wdata(wdata),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .Sb(Sb), .Sh(Sh),
    .ExtrWord(ExtrWord), .ExtrSigned(ExtrSigned), .dm(dm),
    .mem_stall(mem_stall), .load_valid(load_valid), .bus_err(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .load_data(load_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] m_be(input int sz, input logic [1:0] lo);
    return sz == 1 ? 4'(1 << lo) : sz == 2 ? (lo[1] ? 4'd12 : 4'd3) : 4'd15;
  endfunction
  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
    return sz == 1 ? (w & 32'hFF) * 32'h01010101 : sz == 2 ? (w & 32'hFFFF) * 32'h00010001 : w;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] r, input int sz, input logic [1:0] lo, input bit sgn);
    int sh;
    logic [31:0] v;
    if (sz == 4) return r;
    sh = sz == 1 ? 8 * lo : 16 * lo[1];
    v = (r >> sh) & (sz == 1 ? 32'hFF : 32'hFFFF);
    if (sgn && v[8 * sz - 1]) v = v | (sz == 1 ? 32'hFFFFFF00 : 32'hFFFF0000);
    return v;
  endfunction
  // memory responder: grants after gnt_dly waiting REQ cycles, returns data rv_dly cycles later (-1 = never)
  initial begin
    dm.gnt = 0;
    dm.rvalid = 0;
    dm.rdata = 0;
    forever begin
      @(negedge clk);
      #1;
      dm.gnt = 0;
      dm.rvalid = 0;
      dm.rdata = $urandom;
      if (rv_cnt == 0) begin
        dm.rvalid = 1;
        dm.rdata = rd_val;
        rv_cnt = -1;
      end else if (rv_cnt > 0) rv_cnt--;
      if (dm.req) begin
        if (waited == gnt_dly) begin
          dm.gnt = 1;
          waited = 0;
          if (!dm.we) rv_cnt = rv_dly;
        end else waited++;
      end else waited = 0;
    end
  end
  // scoreboard monitor
  initial forever begin
    req_t rq;
    resp_t rs;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (dm.req && dm.gnt) begin
        if (req_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          rq = req_q.pop_front();
          chk("req_we", dm.we, rq.we);
          chk("req_addr", dm.addr, rq.addr);
          if (rq.we) begin
            chk("req_be", dm.be, rq.be);
            chk("req_wdata", dm.wdata, rq.wdata);
          end
        end
      end
      if (load_valid) begin
        if (resp_q.size() == 0) chk("unexpected_load_valid", 1, 0);
        else begin
          rs = resp_q.pop_front();
          chk("resp_kind_load", rs.kind, 0);
          chk("load_data", load_data, rs.data);
        end
      end
      if (bus_err) begin
        if (resp_q.size() == 0) chk("unexpected_bus_err", 1, 0);
        else begin
          rs = resp_q.pop_front();
          chk("resp_kind_err", rs.kind, 1);
        end
      end
`ifdef MEM_MISALIGN_TRAP_EN
      if (misalign) begin
        if (resp_q.size() == 0) chk("unexpected_misalign", 1, 0);
        else begin
          rs = resp_q.pop_front();
          chk("resp_kind_misalign", rs.kind, 2);
        end
      end
`endif
    end
  end
  task automatic do_txn(input bit st, input int sz, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] rd, input bit sgn, input int gd, input int rdd);
    req_t rq;
    resp_t rs;
    int exp_st, n;
    bit mis;
    mis = 0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 0);
`endif
    gnt_dly = gd;
    rv_dly = rdd;
    rd_val = rd;
    if (mis) begin
      rs.kind = 2;
      rs.data = 0;
      resp_q.push_back(rs);
      exp_st = 1;
    end else if (gd < 0) begin
      rs.kind = 1;
      rs.data = 0;
      resp_q.push_back(rs);
      exp_st = 1 + T;
    end else begin
      rq.we = st;
      rq.addr = a & ~32'd3;
      rq.be = m_be(sz, a[1:0]);
      rq.wdata = m_wdata(sz, w);
      req_q.push_back(rq);
      if (st) exp_st = 2 + gd;
      else if (rdd < 0) begin
        rs.kind = 1;
        rs.data = 0;
        resp_q.push_back(rs);
        exp_st = 2 + gd + T;
      end else begin
        rs.kind = 0;
        rs.data = m_load(rd, sz, a[1:0], sgn);
        last_ld = rs.data;
        resp_q.push_back(rs);
        exp_st = 3 + gd + rdd;
      end
    end
    in_valid = 1;
    addr = a;
    wdata = w;
    MemWrite = st;
    MemToReg = st ? 1'($urandom % 2) : 1'b1;
    Sb = st && sz == 1;
    Sh = st && sz == 2;
    ExtrWord = sz == 1 ? 2'b01 : sz == 2 ? 2'b10 : ($urandom % 2 ? 2'b11 : 2'b00);
    ExtrSigned = sgn;
    n = 0;
    do begin
      @(negedge clk);
      if (mem_stall) n++;
    end while (mem_stall && n < 100);
    chk("stall_cycles", n, exp_st);
    chk("load_data_hold", load_data, last_ld);
    @(posedge clk);
    #1;
    in_valid = 0;
    MemWrite = 0;
    MemToReg = 0;
    repeat ($urandom % 3) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit saw;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_req", dm.req, 0);
    chk("rst_be", dm.be, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_load_data", load_data, 0);
    @(posedge clk);
    #1;
    do_txn(1, 1, 32'h1003, 32'h000000AB, 0, 0, 0, 0);
    do_txn(0, 2, 32'h2002, 0, 32'h80011234, 1, 0, 0);
    do_txn(0, 2, 32'h2002, 0, 32'h80011234, 0, 1, 1);
    do_txn(0, 1, 32'h1, 0, 32'h00001234, 0, 3, 2);
    do_txn(0, 4, 32'h3000, 0, 32'hDEADBEEF, 0, 0, -1);
    do_txn(1, 4, 32'h3004, 32'h1, 0, 0, -1, 0);
    do_txn(1, 4, 32'h1002, 32'h12345678, 0, 0, 0, 0);
    do_txn(0, 4, 32'h40, 0, 32'hCAFEF00D, 0, T - 1, T - 1);
    do_txn(0, 1, 32'h43, 0, 32'h80FF7F01, 1, 0, 0);
    // reset while waiting for read data: request drops at once and the late rvalid is ignored
    req_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h5000, wdata: 32'h0});
    gnt_dly = 1;
    rv_dly = 6;
    rd_val = 32'h11223344;
    in_valid = 1;
    addr = 32'h5000;
    MemWrite = 0;
    MemToReg = 1;
    Sb = 0;
    Sh = 0;
    ExtrWord = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(dm.req && dm.gnt) && n < 50);
    chk("rst_test_grant", dm.gnt, 1);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("rst_async_req", dm.req, 0);
    chk("rst_async_stall", mem_stall, 0);
    in_valid = 0;
    MemToReg = 0;
    @(posedge clk);
    #1;
    rst = 0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (load_valid) saw = 1;
    end
    chk("rst_late_rvalid_ignored", saw, 0);
    chk("rst_clears_load_data", load_data, 0);
    last_ld = 0;
    @(posedge clk);
    #1;
    repeat (50) begin
      int sz, gd, rdd;
      sz = $urandom % 3 == 0 ? 1 : $urandom % 2 ? 2 : 4;
      gd = $urandom % 12 == 0 ? -1 : int'($urandom % 4);
      rdd = $urandom % 12 == 0 ? -1 : int'($urandom % 4);
      do_txn(1'($urandom % 2), sz, $urandom, $urandom, $urandom, 1'($urandom % 2), gd, rdd);
    end
    repeat (4) @(posedge clk);
    chk("req_queue_empty", req_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
